// File: rtl/axil_regfile_axis_rd.sv
// axil_regfile_axis_rd: an AXI-Lite host fills a word buffer and writes a length to CTRL.
// The block then streams buffer[0..LEN-1] out as one AXI-Stream frame, with tlast on the final word.
// Ports:
//   clk, rst           - single clock; reset is synchronous and active-high
//   m_axis_*           - stream master (tdata/tvalid/tlast out, tready in)
//   axis_read_num      - count of stream beats since reset (wraps at 2^32)
//   s_axil_*           - AXI-Lite slave
//                        buffer words 0..REG_NUM-1, CTRL at word REG_NUM, STATUS at word REG_NUM+1
// Build option AXIL_REGFILE_AXIS_RD_READBACK_EN:
//   defined   - buffer words can be read back over AXI-Lite (second RAM read port)
//   undefined - buffer reads return 0 with OKAY
module axil_regfile_axis_rd #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned REG_NUM    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [31:0]           axis_read_num,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int unsigned ADDR_SHIFT = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [ADDR_WIDTH-1:0] CTRL_WORD = ADDR_WIDTH'(REG_NUM);
  localparam logic [ADDR_WIDTH-1:0] STAT_WORD = ADDR_WIDTH'(REG_NUM + 1);
  localparam logic [31:0] LEN_MAX     = 32'(REG_NUM);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SEND = 2'd2} state_t;

  logic [DATA_WIDTH-1:0] mem [REG_NUM];

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n, idx_inc, fetch_addr;
  logic [31:0]       len, len_n;
  logic              done, done_n;
  logic              tvalid_n, tlast_n, fetch_en;

  logic [ADDR_WIDTH-1:0] aw_word, ar_word;
  logic [31:0]           wr_len;
  logic                  wr_fire, rd_fire, aw_accept, ar_accept;
  logic                  len_ok, ctrl_ok, ctrl_start, busy;
  logic [1:0]            wr_resp, rd_resp;
  logic [DATA_WIDTH-1:0] rd_data, buf_rd;
  logic                  unused_prot;

  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  // Address decode and channel handshakes
  assign aw_word    = s_axil_awaddr >> ADDR_SHIFT;
  assign ar_word    = s_axil_araddr >> ADDR_SHIFT;
  assign wr_len     = s_axil_wdata[31:0];
  assign wr_fire    = s_axil_awready & s_axil_awvalid & s_axil_wvalid;
  assign rd_fire    = s_axil_arready & s_axil_arvalid;
  assign aw_accept  = s_axil_awvalid & s_axil_wvalid & ~s_axil_awready & ~s_axil_bvalid;
  assign ar_accept  = s_axil_arvalid & ~s_axil_arready & ~s_axil_rvalid;
  assign busy       = (state != IDLE);
  assign len_ok     = (wr_len != 32'd0) && (wr_len <= LEN_MAX);
  assign ctrl_ok    = !busy && len_ok;
  assign ctrl_start = wr_fire && (aw_word == CTRL_WORD) && ctrl_ok;

  // Write response selection
  always_comb begin
    wr_resp = RESP_SLVERR;
    if (aw_word < CTRL_WORD) begin
      wr_resp = RESP_OKAY;
    end else if (aw_word == CTRL_WORD && ctrl_ok) begin
      wr_resp = RESP_OKAY;
    end
  end

`ifdef AXIL_REGFILE_AXIS_RD_READBACK_EN
  assign buf_rd = mem[ar_word[IDX_W-1:0]];
`else
  assign buf_rd = '0;
`endif

  // Read data selection; sampled at the read handshake, so STATUS reflects pre-edge state
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (ar_word < CTRL_WORD) begin
      rd_data = buf_rd;
    end else if (ar_word == CTRL_WORD) begin
      rd_data = DATA_WIDTH'(len);
    end else if (ar_word == STAT_WORD) begin
      rd_data = DATA_WIDTH'({done, busy});
    end else begin
      rd_resp = RESP_SLVERR;
    end
  end

  // AXI-Lite write and read channel registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= 2'b00;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= 2'b00;
      s_axil_rdata   <= '0;
    end else begin
      s_axil_awready <= aw_accept;
      s_axil_wready  <= aw_accept;
      if (wr_fire) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_resp;
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
      s_axil_arready <= ar_accept;
      if (rd_fire) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rresp  <= rd_resp;
        s_axil_rdata  <= rd_data;
      end else if (s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

  // Byte-strobed buffer write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (wr_fire && (aw_word < CTRL_WORD)) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (s_axil_wstrb[b]) begin
          mem[aw_word[IDX_W-1:0]][b*8 +: 8] <= s_axil_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Stream FSM: next-state and next-output logic
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    len_n      = len;
    done_n     = done;
    tvalid_n   = m_axis_tvalid;
    tlast_n    = m_axis_tlast;
    fetch_en   = 1'b0;
    fetch_addr = idx;
    idx_inc    = idx + IDX_W'(1);
    unique case (state)
      IDLE: begin
        if (ctrl_start) begin
          state_n = FETCH;
          idx_n   = '0;
          len_n   = wr_len;
          done_n  = 1'b0;
        end
      end
      FETCH: begin
        fetch_en = 1'b1;
        tvalid_n = 1'b1;
        tlast_n  = (32'(idx) == len - 32'd1);
        state_n  = SEND;
      end
      SEND: begin
        if (m_axis_tready) begin
          if (m_axis_tlast) begin
            state_n  = IDLE;
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            done_n   = 1'b1;
          end else begin
            // Advance and prefetch the next word in the handshake cycle
            idx_n      = idx_inc;
            fetch_en   = 1'b1;
            fetch_addr = idx_inc;
            tlast_n    = (32'(idx_inc) == len - 32'd1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stream FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      len           <= 32'd0;
      done          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      axis_read_num <= 32'd0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      len           <= len_n;
      done          <= done_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tlast  <= tlast_n;
      if (fetch_en) begin
        m_axis_tdata <= mem[fetch_addr];
      end
      if (m_axis_tvalid && m_axis_tready) begin
        axis_read_num <= axis_read_num + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_axil_regfile_axis_rd.sv
// Self-checking bench for axil_regfile_axis_rd: expected stream beats are queued when a
// frame is started and compared as the DUT emits them.
module tb_axil_regfile_axis_rd;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned RN = 1024;
  localparam logic [AW-1:0] CTRL_A = AW'(RN * SW);
  localparam logic [AW-1:0] STAT_A = AW'((RN + 1) * SW);
  localparam logic [AW-1:0] BAD_A  = AW'((RN + 2) * SW);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0]   axis_read_num;
  logic [AW-1:0] s_axil_awaddr, s_axil_araddr;
  logic [2:0]    s_axil_awprot, s_axil_arprot;
  logic          s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [DW-1:0] s_axil_wdata, s_axil_rdata;
  logic [SW-1:0] s_axil_wstrb;
  logic [1:0]    s_axil_bresp, s_axil_rresp;
  logic          s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic          s_axil_rvalid, s_axil_rready;

  axil_regfile_axis_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .REG_NUM(RN)) dut (
    .clk(clk), .rst(rst),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .axis_read_num(axis_read_num),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready), .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr),
    .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int            total = 0;
  int            bad   = 0;
  logic [31:0]   rn_exp = 32'd0;
  logic [DW-1:0] model [16];
  beat_t         exp_q [$];

  // Queue the beats a frame of the given length must produce
  task automatic push_frame(input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = model[i];
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the write handshake
  task automatic axil_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, output logic [1:0] resp);
    int n = 0;
    s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axil_awready && n < 50);
    total++;
    if (!(s_axil_awready === 1'b1 && s_axil_wready === 1'b1)) begin
      bad++; $display("FAIL aw_w_ready addr=%h: awready=%b wready=%b required 1/1", addr, s_axil_awready, s_axil_wready);
    end
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    total++;
    if (s_axil_bvalid !== 1'b1) begin
      bad++; $display("FAIL bvalid addr=%h: got %b required 1", addr, s_axil_bvalid);
    end
    resp = s_axil_bresp;
  endtask

  task automatic axil_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp);
    int n = 0;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axil_arready && n < 50);
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    total++;
    if (s_axil_rvalid !== 1'b1) begin
      bad++; $display("FAIL rvalid addr=%h: got %b required 1", addr, s_axil_rvalid);
    end
    data = s_axil_rdata; resp = s_axil_rresp;
  endtask

  // Drain expected beats; toggle=1 alternates tready, exp_first>=0 checks the first-beat cycle,
  // stop_after>0 returns at the negedge where that beat's handshake is pending
  task automatic run_stream(input bit toggle, input int exp_first, input int stop_after);
    int cyc = 0, beats = 0, last_cyc = -1;
    bit stalled = 1'b0;
    logic [DW-1:0] hold_d;
    logic hold_l;
    beat_t e;
    hold_d = '0; hold_l = 1'b0;
    while (exp_q.size() > 0 && cyc < 200) begin
      m_axis_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (m_axis_tvalid === 1'b1) begin
        if (stalled) begin
          total++;
          if (m_axis_tdata !== hold_d || m_axis_tlast !== hold_l) begin
            bad++; $display("FAIL stall_hold: got %h/%b required %h/%b", m_axis_tdata, m_axis_tlast, hold_d, hold_l);
          end
        end
        if (m_axis_tready) begin
          e = exp_q.pop_front();
          total++;
          if (m_axis_tdata !== e.data) begin
            bad++; $display("FAIL beat%0d_data: got %h required %h", beats, m_axis_tdata, e.data);
          end
          total++;
          if (m_axis_tlast !== e.last) begin
            bad++; $display("FAIL beat%0d_last: got %b required %b", beats, m_axis_tlast, e.last);
          end
          if (beats == 0 && exp_first >= 0) begin
            total++;
            if (cyc != exp_first) begin
              bad++; $display("FAIL first_beat_cycle: got %0d required %0d", cyc, exp_first);
            end
          end
          if (!toggle && beats > 0) begin
            total++;
            if (cyc != last_cyc + 1) begin
              bad++; $display("FAIL beat_gap: got cycle %0d required %0d", cyc, last_cyc + 1);
            end
          end
          last_cyc = cyc; beats++; rn_exp = rn_exp + 32'd1; stalled = 1'b0;
        end else begin
          stalled = 1'b1; hold_d = m_axis_tdata; hold_l = m_axis_tlast;
        end
      end
      if (stop_after > 0 && beats == stop_after) break;
      @(negedge clk); cyc++;
    end
    if (stop_after == 0) begin
      m_axis_tready = 1'b0;
      total++;
      if (exp_q.size() != 0) begin
        bad++; $display("FAIL stream_timeout: %0d beats outstanding required 0", exp_q.size());
        exp_q.delete();
      end
      total++;
      if (m_axis_tvalid !== 1'b0) begin
        bad++; $display("FAIL post_frame_tvalid: got %b required 0", m_axis_tvalid);
      end
      total++;
      if (axis_read_num !== rn_exp) begin
        bad++; $display("FAIL read_num: got %0d required %0d", axis_read_num, rn_exp);
      end
    end
  endtask

  task automatic test_reset;
    logic [DW-1:0] d;
    logic [1:0] r;
    repeat (3) @(negedge clk);
    total++;
    if ({m_axis_tvalid, m_axis_tlast, s_axil_awready, s_axil_bvalid, s_axil_arready, s_axil_rvalid} !== 6'b0 ||
        m_axis_tdata !== '0 || axis_read_num !== 32'd0) begin
      bad++; $display("FAIL reset_outputs: tvalid=%b tlast=%b tdata=%h num=%0d required all 0",
                      m_axis_tvalid, m_axis_tlast, m_axis_tdata, axis_read_num);
    end
    rst = 1'b0;
    @(negedge clk);
    axil_read(STAT_A, d, r);
    total++;
    if (d !== 64'd0) begin bad++; $display("FAIL reset_status: got %h required 0", d); end
    axil_read(CTRL_A, d, r);
    total++;
    if (d !== 64'd0) begin bad++; $display("FAIL reset_len: got %h required 0", d); end
  endtask

  task automatic test_frame;
    logic [DW-1:0] d;
    logic [1:0] r;
    for (int i = 0; i < 4; i++) begin
      model[i] = DW'(8'h11 * (i + 1));
      axil_write(AW'(i * SW), model[i], '1, r);
      total++;
      if (r !== 2'b00) begin bad++; $display("FAIL buf_wr_resp%0d: got %b required 00", i, r); end
    end
    push_frame(4);
    axil_write(CTRL_A, 64'd4, '1, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL ctrl4_resp: got %b required 00", r); end
    run_stream(1'b0, 1, 0);
    axil_read(STAT_A, d, r);
    total++;
    if (d !== 64'd2) begin bad++; $display("FAIL frame_status: got %h required 2", d); end
    axil_read(CTRL_A, d, r);
    total++;
    if (d !== 64'd4) begin bad++; $display("FAIL frame_len: got %h required 4", d); end
  endtask

  task automatic test_stall;
    logic [1:0] r;
    push_frame(4);
    axil_write(CTRL_A, 64'd4, '1, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL stall_ctrl_resp: got %b required 00", r); end
    run_stream(1'b1, -1, 0);
  endtask

  task automatic test_ctrl_errors;
    logic [DW-1:0] d;
    logic [1:0] r;
    bit any_valid;
    axil_write(CTRL_A, 64'd0, '1, r);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL ctrl0_resp: got %b required 10", r); end
    axil_write(CTRL_A, 64'(RN + 1), '1, r);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL ctrl_big_resp: got %b required 10", r); end
    any_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_axis_tvalid !== 1'b0) any_valid = 1'b1;
      @(negedge clk);
    end
    total++;
    if (any_valid) begin bad++; $display("FAIL reject_no_stream: tvalid seen 1 required 0"); end
    axil_read(CTRL_A, d, r);
    total++;
    if (d !== 64'd4) begin bad++; $display("FAIL reject_len: got %h required 4", d); end
    axil_write(STAT_A, 64'd3, '1, r);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL status_wr_resp: got %b required 10", r); end
    axil_read(BAD_A, d, r);
    total++;
    if (r !== 2'b10 || d !== 64'd0) begin bad++; $display("FAIL bad_rd: got %b/%h required 10/0", r, d); end
    push_frame(4);
    axil_write(CTRL_A, 64'd4, '1, r);
    axil_write(CTRL_A, 64'd2, '1, r);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL busy_ctrl_resp: got %b required 10", r); end
    axil_read(STAT_A, d, r);
    total++;
    if (d !== 64'd1) begin bad++; $display("FAIL busy_status: got %h required 1", d); end
    axil_read(CTRL_A, d, r);
    total++;
    if (d !== 64'd4) begin bad++; $display("FAIL busy_len: got %h required 4", d); end
    run_stream(1'b0, -1, 0);
  endtask

  task automatic test_strobe;
    logic [DW-1:0] d, exp_d;
    logic [1:0] r;
    model[4] = 64'h55;
    axil_write(AW'(4 * SW), model[4], '1, r);
    axil_write(AW'(5 * SW), 64'd0, '1, r);
    axil_write(AW'(5 * SW), 64'hFFFFFFFF_FFFFFFFF, 8'h0F, r);
    model[5] = 64'h00000000_FFFFFFFF;
    axil_read(AW'(5 * SW), d, r);
`ifdef AXIL_REGFILE_AXIS_RD_READBACK_EN
    exp_d = model[5];
`else
    exp_d = 64'd0;
`endif
    total++;
    if (d !== exp_d || r !== 2'b00) begin
      bad++; $display("FAIL strobe_readback: got %h/%b required %h/00", d, r, exp_d);
    end
    push_frame(6);
    axil_write(CTRL_A, 64'd6, '1, r);
    run_stream(1'b1, -1, 0);
  endtask

  task automatic test_len1;
    logic [1:0] r;
    push_frame(1);
    axil_write(CTRL_A, 64'd1, '1, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL len1_resp: got %b required 00", r); end
    run_stream(1'b0, 1, 0);
  endtask

  task automatic test_same_cycle;
    int n = 0;
    push_frame(3);
    s_axil_araddr = STAT_A; s_axil_arvalid = 1'b1;
    s_axil_awaddr = CTRL_A; s_axil_wdata = 64'd3; s_axil_wstrb = '1;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axil_awready && n < 50);
    total++;
    if (s_axil_arready !== 1'b1 || s_axil_awready !== 1'b1) begin
      bad++; $display("FAIL same_cycle_ready: ar=%b aw=%b required 1/1", s_axil_arready, s_axil_awready);
    end
    @(negedge clk);
    s_axil_arvalid = 1'b0; s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    total++;
    if (s_axil_rdata !== 64'd2 || s_axil_bresp !== 2'b00) begin
      bad++; $display("FAIL same_cycle_status: got %h/%b required 2/00", s_axil_rdata, s_axil_bresp);
    end
    run_stream(1'b0, 1, 0);
  endtask

  task automatic test_reset_midframe;
    logic [DW-1:0] d;
    logic [1:0] r;
    model[6] = 64'h66; model[7] = 64'h77;
    axil_write(AW'(6 * SW), model[6], '1, r);
    axil_write(AW'(7 * SW), model[7], '1, r);
    push_frame(8);
    axil_write(CTRL_A, 64'd8, '1, r);
    run_stream(1'b0, 1, 2);
    @(negedge clk);
    rst = 1'b1; m_axis_tready = 1'b0;
    @(negedge clk);
    total++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || axis_read_num !== 32'd0) begin
      bad++; $display("FAIL midframe_reset: tvalid=%b tlast=%b num=%0d required 0/0/0",
                      m_axis_tvalid, m_axis_tlast, axis_read_num);
    end
    rst = 1'b0; exp_q.delete(); rn_exp = 32'd0;
    @(negedge clk);
    axil_read(STAT_A, d, r);
    total++;
    if (d !== 64'd0) begin bad++; $display("FAIL midframe_status: got %h required 0", d); end
    axil_read(CTRL_A, d, r);
    total++;
    if (d !== 64'd0) begin bad++; $display("FAIL midframe_len: got %h required 0", d); end
    push_frame(1);
    axil_write(CTRL_A, 64'd1, '1, r);
    run_stream(1'b0, 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    m_axis_tready = 1'b0;
    s_axil_awaddr = '0; s_axil_awprot = 3'd0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b1;
    s_axil_araddr = '0; s_axil_arprot = 3'd0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    test_reset();
    test_frame();
    test_stall();
    test_ctrl_errors();
    test_strobe();
    test_len1();
    test_same_cycle();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
